// File: rtl/fwd_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard_pkg
//   Shared types and helpers for the forwarding scoreboard.
//   - forward_mux_code_e : select encoding used by the core's forwarding muxes
//     when FWD_DEPTH=2 (0 regfile, 1 EX/MEM, 2 MEM/WB).
//   - to_fwd_mux_code    : casts a raw scoreboard select into that encoding.
//   - opcode_e           : RV32 major opcodes.
//   - src_used_mask      : decodes which source operands an opcode reads.
// ---------------------------------------------------------------------------
package fwd_scoreboard_pkg;

   localparam int DEF_NUM_SRC    = 2;
   localparam int DEF_FWD_DEPTH  = 2;
   localparam int DEF_REG_ADDR_W = 5;
   localparam int DEF_LOAD_LAT   = 1;

   typedef enum logic [1:0] {
      ORIGINAL_SELECT  = 2'd0,
      EX_RESULT_SELECT = 2'd1,
      WB_RESULT_SELECT = 2'd2
   } forward_mux_code_e;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OPIMM  = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111
   } opcode_e;

   function automatic forward_mux_code_e to_fwd_mux_code(input logic [1:0] sel);
      return forward_mux_code_e'(sel);
   endfunction

   // bit0 = rs1 read, bit1 = rs2 read
   function automatic logic [1:0] src_used_mask(input logic [6:0] opcode);
      logic [1:0] m;
      case (opcode)
         OPC_BRANCH, OPC_STORE, OPC_OP: m = 2'b11;
         OPC_LOAD, OPC_JALR, OPC_OPIMM: m = 2'b01;
         default:                       m = 2'b00;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/fwd_scoreboard_src_match.sv
// ---------------------------------------------------------------------------
// fwd_src_match
//   Priority matcher for one source operand against the scoreboard.
//   Ports:
//     i_src      source register address
//     i_used     operand is actually read by the instruction
//     i_valid    per-entry valid bits (index 0 = youngest)
//     i_dest     per-entry destination registers
//     i_is_load  per-entry load flag
//     o_sel      0 = regfile, k+1 = forward from entry k
//     o_hazard   winning entry is a load whose data is not yet forwardable
// ---------------------------------------------------------------------------
module fwd_src_match #(
   parameter int FWD_DEPTH  = 2,
   parameter int REG_ADDR_W = 5,
   parameter int LOAD_LAT   = 1,
   parameter int FWD_SEL_W  = 2
) (
   input  logic [REG_ADDR_W-1:0]                i_src,
   input  logic                                 i_used,
   input  logic [FWD_DEPTH-1:0]                 i_valid,
   input  logic [FWD_DEPTH-1:0][REG_ADDR_W-1:0] i_dest,
   input  logic [FWD_DEPTH-1:0]                 i_is_load,
   output logic [FWD_SEL_W-1:0]                 o_sel,
   output logic                                 o_hazard
);

   logic [FWD_SEL_W-1:0] w_sel;
   logic                 w_hazard;

   // Scan oldest to youngest so the youngest match is the last one written.
   always_comb begin
      w_sel    = '0;
      w_hazard = 1'b0;
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
         if (i_used && (i_src != '0) && i_valid[k] && (i_dest[k] == i_src)) begin
            w_sel    = FWD_SEL_W'(k + 1);
            w_hazard = i_is_load[k] && (k < LOAD_LAT);
         end
      end
   end

   assign o_sel    = w_sel;
   assign o_hazard = w_hazard;

endmodule

// File: rtl/fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard
//   Shift-register scoreboard of in-flight destination registers behind ID.
//   Produces per-source forward selects and a load-use stall, combinationally
//   from the board and the ID inputs.
//   Ports:
//     clk, reset          rising-edge clock, async active-low reset
//     id_valid_ip         instruction present in ID
//     id_src_ip           packed source addresses, src i at [i*REG_ADDR_W +: REG_ADDR_W]
//     id_src_used_ip      per-source read mask
//     id_reg_write_ip     ID instruction writes back
//     id_is_load_ip       ID instruction is a load
//     id_dest_ip          ID destination register
//     flush_ip            kill the ID instruction
//     fwd_sel_op          per-source select (0 regfile, k = entry k-1)
//     stall_op            hold IF/ID, insert bubble
//   Optional (macro FWD_SCOREBOARD_STATS_EN):
//     stall_cnt_op        cycles with stall_op=1
//     fwd_cnt_op          accepted instructions that used any forward path
// ---------------------------------------------------------------------------
module fwd_scoreboard
   import fwd_scoreboard_pkg::*;
#(
   parameter  int NUM_SRC    = DEF_NUM_SRC,
   parameter  int FWD_DEPTH  = DEF_FWD_DEPTH,
   parameter  int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter  int LOAD_LAT   = DEF_LOAD_LAT,
   localparam int FWD_SEL_W  = $clog2(FWD_DEPTH + 1)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            id_valid_ip,
   input  logic [NUM_SRC*REG_ADDR_W-1:0]   id_src_ip,
   input  logic [NUM_SRC-1:0]              id_src_used_ip,
   input  logic                            id_reg_write_ip,
   input  logic                            id_is_load_ip,
   input  logic [REG_ADDR_W-1:0]           id_dest_ip,
   input  logic                            flush_ip,
   output logic [NUM_SRC*FWD_SEL_W-1:0]    fwd_sel_op,
   output logic                            stall_op
`ifdef FWD_SCOREBOARD_STATS_EN
   ,
   output logic [31:0]                     stall_cnt_op,
   output logic [31:0]                     fwd_cnt_op
`endif
);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] dest;
      logic                  is_load;
   } sb_entry_t;

   sb_entry_t [FWD_DEPTH-1:0]              r_board;
   sb_entry_t                              w_new;
   logic [FWD_DEPTH-1:0]                   w_valid;
   logic [FWD_DEPTH-1:0]                   w_is_load;
   logic [FWD_DEPTH-1:0][REG_ADDR_W-1:0]   w_dest;
   logic [NUM_SRC-1:0]                     w_hazard;
   logic                                   w_stall;
   logic                                   w_accept;

   genvar g;
   generate
      for (g = 0; g < FWD_DEPTH; g++) begin : g_unpack
         assign w_valid[g]   = r_board[g].valid;
         assign w_is_load[g] = r_board[g].is_load;
         assign w_dest[g]    = r_board[g].dest;
      end

      for (g = 0; g < NUM_SRC; g++) begin : g_src
         fwd_src_match #(
            .FWD_DEPTH  (FWD_DEPTH),
            .REG_ADDR_W (REG_ADDR_W),
            .LOAD_LAT   (LOAD_LAT),
            .FWD_SEL_W  (FWD_SEL_W)
         ) u_match (
            .i_src     (id_src_ip[g*REG_ADDR_W +: REG_ADDR_W]),
            .i_used    (id_src_used_ip[g]),
            .i_valid   (w_valid),
            .i_dest    (w_dest),
            .i_is_load (w_is_load),
            .o_sel     (fwd_sel_op[g*FWD_SEL_W +: FWD_SEL_W]),
            .o_hazard  (w_hazard[g])
         );
      end
   endgenerate

   // Flush beats stall: a killed instruction must not hold the front end.
   assign w_stall  = (|w_hazard) & id_valid_ip & ~flush_ip;
   assign stall_op = w_stall;
   assign w_accept = id_valid_ip & ~w_stall & ~flush_ip;

   // x0 writes are dropped so they can never shadow a real producer.
   always_comb begin
      w_new = '0;
      if (w_accept && id_reg_write_ip && (id_dest_ip != '0)) begin
         w_new.valid   = 1'b1;
         w_new.dest    = id_dest_ip;
         w_new.is_load = id_is_load_ip;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_board <= '0;
      end else begin
         for (int k = FWD_DEPTH - 1; k > 0; k--) r_board[k] <= r_board[k-1];
         r_board[0] <= w_new;
      end
   end

`ifdef FWD_SCOREBOARD_STATS_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_fwd_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
         r_fwd_cnt   <= '0;
      end else begin
         if (w_stall)                   r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_accept && |fwd_sel_op)   r_fwd_cnt   <= r_fwd_cnt + 32'd1;
      end
   end

   assign stall_cnt_op = r_stall_cnt;
   assign fwd_cnt_op   = r_fwd_cnt;
`endif

endmodule
